// File: rtl/merlin_fifo_arbiter.sv
// merlin_fifo_arbiter: round-robin merge of requester beats into one FIFO, with locked bursts capped at C_BURST_MAX
module merlin_fifo_arbiter #(
    parameter int C_NUM_REQ   = 4,
    parameter int C_WIDTH     = 32,
    parameter int C_BURST_MAX = 4
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           clk_en_i,
    input  logic                           flush_i,
    input  logic [C_NUM_REQ-1:0]           req_i,
    input  logic [C_NUM_REQ-1:0]           last_i,
    input  logic [C_NUM_REQ*C_WIDTH-1:0]   data_i,
    output logic [C_NUM_REQ-1:0]           ack_o,
    input  logic                           fifo_full_i,
    output logic                           fifo_wr_o,
    output logic [C_WIDTH-1:0]             fifo_din_o,
    output logic [$clog2(C_NUM_REQ)-1:0]   fifo_src_o,
    output logic                           busy_o
);
    localparam int SW = $clog2(C_NUM_REQ);
    localparam int CW = $clog2(C_BURST_MAX) + 1;
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t          state_q, state_d;
    logic [SW-1:0]   rr_ptr_q, rr_ptr_d, owner_q, owner_d, win, sel;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
    logic            found, go, term;
    always_comb begin
        win   = '0;
        found = 1'b0;
        // downward scan so the requester closest to rr_ptr_q wins; pointer wrap relies on power-of-two C_NUM_REQ
        for (int i = C_NUM_REQ - 1; i >= 0; i--)
            if (req_i[rr_ptr_q + SW'(i)]) begin
                win   = rr_ptr_q + SW'(i);
                found = 1'b1;
            end
        sel        = (state_q == LOCKED) ? owner_q : win;
        go         = clk_en_i & ~flush_i & ~reset_i & ~fifo_full_i & ((state_q == LOCKED) ? req_i[owner_q] : found);
        ack_o      = go ? (C_NUM_REQ'(1) << sel) : '0;
        fifo_wr_o  = go;
        fifo_din_o = go ? data_i[sel*C_WIDTH +: C_WIDTH] : '0;
        fifo_src_o = go ? sel : '0;
        busy_o     = (state_q == LOCKED) & ~reset_i;
        term       = last_i[sel] | ((state_q == LOCKED) & ((beat_cnt_q + CW'(1)) == CW'(C_BURST_MAX)));
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        if (clk_en_i & flush_i) begin
            state_d    = IDLE;
            rr_ptr_d   = '0;
            owner_d    = '0;
            beat_cnt_d = '0;
        end else if (go & term) begin
            state_d    = IDLE;
            rr_ptr_d   = sel + SW'(1);
            beat_cnt_d = '0;
        end else if (go) begin
            state_d    = LOCKED;
            owner_d    = sel;
            beat_cnt_d = beat_cnt_q + CW'(1);
        end
    end
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end
endmodule

// File: tb/tb_merlin_fifo_arbiter.sv
// tb_merlin_fifo_arbiter: directed scenarios plus random traffic checked against a behavioural arbiter model
module tb_merlin_fifo_arbiter;
    localparam int N = 4;
    localparam int W = 32;
    localparam int BMAX = 4;
    logic           clk = 1'b0;
    logic           reset_i, clk_en_i, flush_i, fifo_full_i;
    logic [N-1:0]   req_i, last_i;
    logic [N*W-1:0] data_i;
    logic [N-1:0]   ack_o;
    logic           fifo_wr_o, busy_o;
    logic [W-1:0]   fifo_din_o;
    logic [1:0]     fifo_src_o;
    int errors = 0;
    int checks = 0;
    bit m_locked = 0;
    int m_rr = 0, m_owner = 0, m_cnt = 0;

    merlin_fifo_arbiter #(.C_NUM_REQ(N), .C_WIDTH(W), .C_BURST_MAX(BMAX)) dut (
        .clk_i(clk), .reset_i(reset_i), .clk_en_i(clk_en_i), .flush_i(flush_i),
        .req_i(req_i), .last_i(last_i), .data_i(data_i), .ack_o(ack_o),
        .fifo_full_i(fifo_full_i), .fifo_wr_o(fifo_wr_o), .fifo_din_o(fifo_din_o),
        .fifo_src_o(fifo_src_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    function automatic int m_grant();
        if (reset_i || flush_i || !clk_en_i || fifo_full_i) return -1;
        if (m_locked) return req_i[m_owner] ? m_owner : -1;
        for (int i = 0; i < N; i++)
            if (req_i[(m_rr + i) % N]) return (m_rr + i) % N;
        return -1;
    endfunction

    task automatic m_update();
        int g;
        g = m_grant();
        if (reset_i || (clk_en_i && flush_i)) begin
            m_locked = 0; m_rr = 0; m_owner = 0; m_cnt = 0;
        end else if (g >= 0 && !m_locked) begin
            if (last_i[g]) m_rr = (g + 1) % N;
            else begin m_locked = 1; m_owner = g; m_cnt = 1; end
        end else if (g >= 0) begin
            m_cnt++;
            if (last_i[g] || m_cnt == BMAX) begin m_locked = 0; m_rr = (m_owner + 1) % N; m_cnt = 0; end
        end
    endtask

    task automatic set_in(input logic [3:0] r, input logic [3:0] l, input logic full, input logic en, input logic fl, input logic rst);
        req_i = r; last_i = l; fifo_full_i = full; clk_en_i = en; flush_i = fl; reset_i = rst;
        data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
        #1;
    endtask

    task automatic tick();
        m_update();
        @(negedge clk);
    endtask

    task automatic do_flush();
        set_in(4'h0, 4'h0, 0, 1, 1, 0);
        tick();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            set_in(4'hF, 4'h0, 0, 1, 0, 1);
            checks++;
            if ({ack_o, fifo_wr_o, fifo_din_o, fifo_src_o, busy_o} !== '0) begin
                errors++; $display("FAIL reset_hold cycle %0d ack=%b wr=%b src=%0d busy=%b want all 0", i, ack_o, fifo_wr_o, fifo_src_o, busy_o);
            end
            tick();
        end
        set_in(4'h0, 4'h0, 0, 1, 0, 0);
        checks++;
        if ({ack_o, fifo_wr_o, fifo_din_o, fifo_src_o, busy_o} !== '0) begin
            errors++; $display("FAIL reset_after ack=%b wr=%b busy=%b want all 0", ack_o, fifo_wr_o, busy_o);
        end
        tick();
    endtask

    task automatic test_round_robin();
        do_flush();
        for (int i = 0; i < 5; i++) begin
            set_in(4'hF, 4'hF, 0, 1, 0, 0);
            checks++;
            if (ack_o !== 4'(1 << (i % 4)) || fifo_wr_o !== 1'b1 || fifo_src_o !== 2'(i % 4)) begin
                errors++; $display("FAIL rr_order beat %0d ack=%b src=%0d want ack=%b src=%0d", i, ack_o, fifo_src_o, 4'(1 << (i % 4)), i % 4);
            end
            checks++;
            if (fifo_din_o !== data_i[(i % 4)*W +: W]) begin
                errors++; $display("FAIL rr_data beat %0d din=%h want %h", i, fifo_din_o, data_i[(i % 4)*W +: W]);
            end
            tick();
        end
    endtask

    task automatic test_burst_max();
        logic [3:0] ea[5] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
        logic       eb[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        do_flush();
        for (int i = 0; i < 5; i++) begin
            set_in(4'b0011, 4'h0, 0, 1, 0, 0);
            checks++;
            if (ack_o !== ea[i]) begin
                errors++; $display("FAIL burst_ack cycle %0d ack=%b want %b", i, ack_o, ea[i]);
            end
            checks++;
            if (busy_o !== eb[i]) begin
                errors++; $display("FAIL burst_busy cycle %0d busy=%b want %b", i, busy_o, eb[i]);
            end
            tick();
        end
    endtask

    task automatic test_full_stall();
        do_flush();
        set_in(4'b0100, 4'h0, 0, 1, 0, 0);
        checks++;
        if (ack_o !== 4'b0100) begin errors++; $display("FAIL stall_start ack=%b want 0100", ack_o); end
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(4'hF, 4'h0, 1, 1, 0, 0);
            checks++;
            if (ack_o !== 4'b0 || fifo_wr_o !== 1'b0 || busy_o !== 1'b1) begin
                errors++; $display("FAIL stall_hold cycle %0d ack=%b wr=%b busy=%b want 0000 0 1", i, ack_o, fifo_wr_o, busy_o);
            end
            checks++;
            if (dut.beat_cnt_q !== 3'd1) begin errors++; $display("FAIL stall_cnt cycle %0d cnt=%0d want 1", i, dut.beat_cnt_q); end
            tick();
        end
        set_in(4'hF, 4'h0, 0, 1, 0, 0);
        checks++;
        if (ack_o !== 4'b0100) begin errors++; $display("FAIL stall_resume ack=%b want 0100", ack_o); end
        tick();
        set_in(4'hF, 4'b0100, 0, 1, 0, 0);
        checks++;
        if (ack_o !== 4'b0100 || busy_o !== 1'b1) begin errors++; $display("FAIL stall_last ack=%b busy=%b want 0100 1", ack_o, busy_o); end
        tick();
        set_in(4'hF, 4'h0, 0, 1, 0, 0);
        checks++;
        if (ack_o !== 4'b1000 || busy_o !== 1'b0) begin errors++; $display("FAIL stall_next ack=%b busy=%b want 1000 0", ack_o, busy_o); end
        tick();
    endtask

    task automatic test_flush();
        do_flush();
        set_in(4'b0010, 4'h0, 0, 1, 0, 0);
        checks++;
        if (ack_o !== 4'b0010) begin errors++; $display("FAIL flush_lock ack=%b want 0010", ack_o); end
        tick();
        set_in(4'b1011, 4'h0, 0, 1, 1, 0);
        checks++;
        if (ack_o !== 4'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL flush_cycle ack=%b busy=%b want 0000 1", ack_o, busy_o); end
        tick();
        set_in(4'b1001, 4'hF, 0, 1, 0, 0);
        checks++;
        if (ack_o !== 4'b0001 || busy_o !== 1'b0) begin errors++; $display("FAIL flush_after ack=%b busy=%b want 0001 0", ack_o, busy_o); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_flush();
        set_in(4'b0010, 4'h0, 0, 1, 0, 0);
        tick();
        set_in(4'hF, 4'h0, 0, 0, 0, 1);
        checks++;
        if ({ack_o, fifo_wr_o, fifo_din_o, fifo_src_o, busy_o} !== '0) begin
            errors++; $display("FAIL rstmid_during ack=%b wr=%b busy=%b want all 0", ack_o, fifo_wr_o, busy_o);
        end
        tick();
        set_in(4'h0, 4'h0, 0, 1, 0, 0);
        checks++;
        if ({ack_o, fifo_wr_o, fifo_din_o, fifo_src_o, busy_o} !== '0) begin
            errors++; $display("FAIL rstmid_after ack=%b wr=%b busy=%b want all 0", ack_o, fifo_wr_o, busy_o);
        end
        tick();
        set_in(4'b1001, 4'hF, 0, 1, 0, 0);
        checks++;
        if (ack_o !== 4'b0001) begin errors++; $display("FAIL rstmid_ptr ack=%b want 0001", ack_o); end
        tick();
    endtask

    task automatic test_clk_en();
        do_flush();
        for (int i = 0; i < 2; i++) begin
            set_in(4'b0010, 4'hF, 0, 0, 0, 0);
            checks++;
            if (ack_o !== 4'b0 || fifo_wr_o !== 1'b0) begin
                errors++; $display("FAIL clken_off cycle %0d ack=%b wr=%b want 0000 0", i, ack_o, fifo_wr_o);
            end
            tick();
        end
        set_in(4'b0010, 4'hF, 0, 1, 0, 0);
        checks++;
        if (ack_o !== 4'b0010 || fifo_src_o !== 2'd1) begin errors++; $display("FAIL clken_on ack=%b src=%0d want 0010 1", ack_o, fifo_src_o); end
        tick();
        set_in(4'hF, 4'hF, 0, 1, 0, 0);
        checks++;
        if (ack_o !== 4'b0100) begin errors++; $display("FAIL clken_ptr ack=%b want 0100", ack_o); end
        tick();
    endtask

    task automatic test_random();
        int g;
        logic [3:0]   ea;
        logic [1:0]   es;
        logic [W-1:0] ed;
        logic         eb;
        do_flush();
        for (int i = 0; i < 400; i++) begin
            set_in(4'($urandom()), 4'($urandom() & $urandom()), $urandom_range(0, 3) == 0,
                   $urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0, $urandom_range(0, 49) == 0);
            g  = m_grant();
            ea = (g < 0) ? 4'b0 : 4'(1 << g);
            es = (g < 0) ? 2'd0 : 2'(g);
            ed = '0;
            if (g >= 0) ed = data_i[g*W +: W];
            eb = m_locked && !reset_i;
            checks++;
            if ({ack_o, fifo_wr_o, fifo_src_o, fifo_din_o, busy_o} !== {ea, ea != 4'b0, es, ed, eb}) begin
                errors++;
                $display("FAIL random cycle %0d ack=%b wr=%b src=%0d din=%h busy=%b want ack=%b wr=%b src=%0d din=%h busy=%b",
                         i, ack_o, fifo_wr_o, fifo_src_o, fifo_din_o, busy_o, ea, ea != 4'b0, es, ed, eb);
            end
            tick();
        end
    endtask

    initial begin
        reset_i = 1; clk_en_i = 1; flush_i = 0; fifo_full_i = 0; req_i = 0; last_i = 0; data_i = '0;
        @(negedge clk);
        test_reset();
        test_round_robin();
        test_burst_max();
        test_full_stall();
        test_flush();
        test_reset_mid();
        test_clk_en();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/merlin_fifo_arbiter.md
MERLIN_FIFO_ARBITER -- requirements
Module: merlin_fifo_arbiter

Interface
REQ-001 Parameter C_NUM_REQ, default 4, number of requesters; legal values 2 and 4.
REQ-002 Parameter C_WIDTH, default 32, data width per requester.
REQ-003 Parameter C_BURST_MAX, default 4, maximum beats per locked burst; legal range 2 to 16.
REQ-004 clk_i  in  1  single clock; all state updates on the rising edge.
REQ-005 reset_i  in  1  synchronous, active-high reset.
REQ-006 clk_en_i  in  1  clock enable; when low, no state changes.
REQ-007 flush_i  in  1  abandons any burst and returns the block to the reset state.
REQ-008 req_i  in  C_NUM_REQ  per-requester beat valid.
REQ-009 last_i  in  C_NUM_REQ  per-requester last-beat marker.
REQ-010 data_i  in  C_NUM_REQ*C_WIDTH  packed beats; requester k occupies bits [k*C_WIDTH +: C_WIDTH].
REQ-011 ack_o  out  C_NUM_REQ  one-hot or zero; beat accepted this cycle.
REQ-012 fifo_full_i  in  1  full flag of the downstream FIFO.
REQ-013 fifo_wr_o  out  1  write strobe to the downstream FIFO.
REQ-014 fifo_din_o  out  C_WIDTH  data of the acked requester.
REQ-015 fifo_src_o  out  log2(C_NUM_REQ)  index of the acked requester.
REQ-016 busy_o  out  1  high while in LOCKED.

Function
REQ-017 State machine: IDLE and LOCKED; registers: rr_ptr_q, owner_q, beat_cnt_q (width log2(C_BURST_MAX)+1).
REQ-018 Outputs ack_o, fifo_wr_o, fifo_din_o and fifo_src_o shall be combinational from the registered state and the current inputs; latency from req to ack is zero cycles.
REQ-019 No beat shall be acked when any of the following holds: fifo_full_i=1, clk_en_i=0, flush_i=1 or reset_i=1.
REQ-020 IDLE: the winner is the first set req_i bit searching upward from rr_ptr_q, wrapping modulo C_NUM_REQ; the winner is acked.
REQ-021 IDLE accept with last_i[winner]=1: remain IDLE; rr_ptr_q <= (winner+1) mod C_NUM_REQ.
REQ-022 IDLE accept with last_i[winner]=0: go to LOCKED; owner_q <= winner; beat_cnt_q <= 1.
REQ-023 LOCKED: only owner_q may be acked, and only when req_i[owner_q]=1; all other requests are ignored.
REQ-024 LOCKED with the owner's request deasserted: hold state indefinitely with no timeout; only flush_i or reset_i releases it.
REQ-025 LOCKED accept: beat_cnt_q increments; the burst terminates when last_i[owner_q]=1 or beat_cnt_q+1 == C_BURST_MAX, whichever comes first; the forced termination at C_BURST_MAX is silent.
REQ-026 Burst termination: go to IDLE; rr_ptr_q <= (owner_q+1) mod C_NUM_REQ; beat_cnt_q <= 0.
REQ-027 fifo_wr_o = OR of ack_o.
REQ-028 fifo_din_o and fifo_src_o reflect the acked requester; both are 0 when no beat is acked.
REQ-029 fifo_full_i rising mid-burst stalls the burst; state and counters hold.
REQ-030 flush_i with clk_en_i=1: state IDLE; rr_ptr_q, owner_q and beat_cnt_q cleared.
REQ-031 flush_i with clk_en_i=0: state holds, and ack_o remains suppressed per REQ-019.
REQ-032 busy_o = (state == LOCKED), registered-state derived.

Reset
REQ-033 reset_i=1 at a clock edge overrides clk_en_i and flush_i.
REQ-034 Reset values: state IDLE, rr_ptr_q=0, owner_q=0, beat_cnt_q=0.
REQ-035 All outputs shall be 0 during and immediately after reset, including when reset is asserted mid-burst.

Verification
REQ-036 All four requesters with continuous single-beat requests (last_i=4'hF), FIFO never full -> ack order 0,1,2,3,0, one per cycle, fifo_src_o matching.
REQ-037 req0 burst with last_i=0 for 6 beats while req1 is asserted (C_BURST_MAX=4) -> 4 consecutive acks to 0, busy_o high for 3 cycles, then req1 is acked next.
REQ-038 req2 locked burst with fifo_full_i high for 3 cycles mid-burst -> no acks for those cycles, beat_cnt_q unchanged, burst resumes on 2 only.
REQ-039 flush_i asserted during LOCKED owner=1 -> ack_o=0 that cycle; next cycle IDLE with rr_ptr_q=0, so req0 wins over req3.
REQ-040 reset_i asserted mid-burst with clk_en_i=0 -> next cycle busy_o=0, all outputs 0, rr_ptr_q=0.
REQ-041 clk_en_i=0 with req_i=4'b0010 -> ack_o=0, fifo_wr_o=0, no pointer change; on re-enable, req1 is acked.
